// File: rtl/vga_pkg.sv
// Shared timing constants and helpers for the VGA raster generator family.
// Defaults describe the standard 640x480@60 mode.
package vga_pkg;

    localparam int DEF_HD  = 640;
    localparam int DEF_HFP = 16;
    localparam int DEF_HSW = 96;
    localparam int DEF_HBP = 48;
    localparam int DEF_VD  = 480;
    localparam int DEF_VFP = 10;
    localparam int DEF_VSW = 2;
    localparam int DEF_VBP = 33;

    // Registered sync/blank bundle; kept together so all three share one decode.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } vga_sync_t;

    function automatic int h_total(input int hd, input int hfp, input int hsw, input int hbp);
        return hd + hfp + hsw + hbp;
    endfunction

    function automatic int v_total(input int vd, input int vfp, input int vsw, input int vbp);
        return vd + vfp + vsw + vbp;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator (master) and pixel renderers (slave).
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
    parameter int CNT_W = 10
);
    // Strobe semantics: en is a level input (low = idle). p_tick, line_end and
    // frame_end are single-clk pulses; consumers act on them in the cycle they are
    // high, with pixel_x/pixel_y/hsync/vsync/video_on describing that same pixel.
    logic             en;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic             p_tick;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             line_end;
    logic             frame_end;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0]       frame_cnt;

    modport master (
        input  en,
        output hsync, vsync, video_on, p_tick, pixel_x, pixel_y,
        output line_end, frame_end, frame_cnt
    );

    modport slave (
        output en,
        input  hsync, vsync, video_on, p_tick, pixel_x, pixel_y,
        input  line_end, frame_end, frame_cnt
    );
`else
    modport master (
        input  en,
        output hsync, vsync, video_on, p_tick, pixel_x, pixel_y,
        output line_end, frame_end
    );

    modport slave (
        output en,
        input  hsync, vsync, video_on, p_tick, pixel_x, pixel_y,
        input  line_end, frame_end
    );
`endif

endinterface

// File: rtl/vga_tick_div.sv
// Generic divide-by-DIV strobe generator with run enable; tick is a registered
// one-clk pulse every DIV clocks while en is high, cleared whenever en is low.
module vga_tick_div
    import vga_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int            DW   = cnt_width(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          tick_q, tick_d;

    always_comb begin
        div_d  = div_q;
        tick_d = 1'b0;
        if (!en) begin
            div_d = '0;
        end else begin
            tick_d = (div_q == LAST);
            div_d  = (div_q == LAST) ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel divider, H/V counters, syncs,
// blanking and line/frame strobes. Define VGA_FRAME_CNT_EN to add an 8-bit frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CNT_W  = 10,
    parameter int DIV    = 2,
    parameter int HD     = DEF_HD,
    parameter int HFP    = DEF_HFP,
    parameter int HSW    = DEF_HSW,
    parameter int HBP    = DEF_HBP,
    parameter int VD     = DEF_VD,
    parameter int VFP    = DEF_VFP,
    parameter int VSW    = DEF_VSW,
    parameter int VBP    = DEF_VBP,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input logic              clk,
    input logic              reset,
    vga_timing_gen_if.master vif
);

    localparam int H_TOTAL = h_total(HD, HFP, HSW, HBP);
    localparam int V_TOTAL = v_total(VD, VFP, VSW, VBP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_DISP   = CNT_W'(HD);
    localparam logic [CNT_W-1:0] V_DISP   = CNT_W'(VD);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(HD + HFP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(HD + HFP + HSW - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(VD + VFP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(VD + VFP + VSW - 1);

    localparam vga_sync_t SYNC_IDLE = '{hsync: ~HS_POL, vsync: ~VS_POL, video_on: 1'b0};

    logic             p_tick;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    vga_sync_t        sync_q, sync_d;
    logic             line_end;
    logic             frame_end;

    vga_tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .en    (vif.en),
        .tick  (p_tick)
    );

    assign line_end  = p_tick & (h_q == H_LAST);
    assign frame_end = line_end & (v_q == V_LAST);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!vif.en) begin
            h_d = '0;
            v_d = '0;
        end else if (p_tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Decode from the next-state counters so the registered syncs line up with pixel_x/pixel_y.
    always_comb begin
        sync_d.hsync    = ((h_d >= HS_START) && (h_d <= HS_END)) ? HS_POL : ~HS_POL;
        sync_d.vsync    = ((v_d >= VS_START) && (v_d <= VS_END)) ? VS_POL : ~VS_POL;
        sync_d.video_on = vif.en & (h_d < H_DISP) & (v_d < V_DISP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_q    <= '0;
            v_q    <= '0;
            sync_q <= SYNC_IDLE;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            sync_q <= sync_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (!vif.en) begin
            frame_cnt_d = '0;
        end else if (frame_end) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vif.frame_cnt = frame_cnt_q;
`endif

    assign vif.hsync     = sync_q.hsync;
    assign vif.vsync     = sync_q.vsync;
    assign vif.video_on  = sync_q.video_on;
    assign vif.p_tick    = p_tick;
    assign vif.pixel_x   = h_q;
    assign vif.pixel_y   = v_q;
    assign vif.line_end  = line_end;
    assign vif.frame_end = frame_end;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-mode instances (DIV=2 active-low syncs, DIV=1
// active-high syncs) checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

    localparam int CW = 10;
    localparam int W  = 34;

    // Instance A timing
    localparam int A_DIV = 2;
    localparam int A_HD = 16, A_HFP = 4, A_HSW = 6, A_HBP = 4;
    localparam int A_VD = 10, A_VFP = 2, A_VSW = 3, A_VBP = 2;
    // Instance B timing
    localparam int B_DIV = 1;
    localparam int B_HD = 4, B_HFP = 2, B_HSW = 3, B_HBP = 2;
    localparam int B_VD = 3, B_VFP = 1, B_VSW = 2, B_VBP = 1;
    localparam int B_FRAME = (B_HD + B_HFP + B_HSW + B_HBP) * (B_VD + B_VFP + B_VSW + B_VBP);

    logic clk = 1'b0;
    logic reset = 1'b0;

    int total = 0;
    int bad = 0;

    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];

    int k_a = 0;
    int k_b = 0;
    int b_frame_seen = 0;

    vga_timing_gen_if #(.CNT_W(CW)) a_if ();
    vga_timing_gen_if #(.CNT_W(CW)) b_if ();

    vga_timing_gen #(
        .CNT_W(CW), .DIV(A_DIV),
        .HD(A_HD), .HFP(A_HFP), .HSW(A_HSW), .HBP(A_HBP),
        .VD(A_VD), .VFP(A_VFP), .VSW(A_VSW), .VBP(A_VBP),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .vif   (a_if.master)
    );

    vga_timing_gen #(
        .CNT_W(CW), .DIV(B_DIV),
        .HD(B_HD), .HFP(B_HFP), .HSW(B_HSW), .HBP(B_HBP),
        .VD(B_VD), .VFP(B_VFP), .VSW(B_VSW), .VBP(B_VBP),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .vif   (b_if.master)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // k = number of consecutive clk edges with en sampled high since reset/en low.
    // Pixel n advances at the edge after each tick; ticks land on edges DIV, 2*DIV, ...
    function automatic logic [W-1:0] ref_model(input int k, input int div,
        input int hd, input int hfp, input int hsw, input int hbp,
        input int vd, input int vfp, input int vsw, input int vbp,
        input bit hp, input bit vp);
        int ht, vt, n, x, y, fc;
        bit pt, le, fe, hs_act, vs_act, von;
        ht = hd + hfp + hsw + hbp;
        vt = vd + vfp + vsw + vbp;
        n  = (k > 0) ? (k - 1) / div : 0;
        x  = n % ht;
        y  = (n / ht) % vt;
        pt = (k > 0) && (k % div == 0);
        le = pt && (x == ht - 1);
        fe = le && (y == vt - 1);
        hs_act = (x >= hd + hfp) && (x < hd + hfp + hsw);
        vs_act = (y >= vd + vfp) && (y < vd + vfp + vsw);
        von = (k > 0) && (x < hd) && (y < vd);
`ifdef VGA_FRAME_CNT_EN
        fc = (n / (ht * vt)) % 256;
`else
        fc = 0;
`endif
        return {(hs_act ? hp : !hp), (vs_act ? vp : !vp), von, pt, le, fe,
                CW'(x), CW'(y), 8'(fc)};
    endfunction

    function automatic logic [W-1:0] exp_a(input int k);
        return ref_model(k, A_DIV, A_HD, A_HFP, A_HSW, A_HBP, A_VD, A_VFP, A_VSW, A_VBP, 1'b0, 1'b0);
    endfunction

    function automatic logic [W-1:0] exp_b(input int k);
        return ref_model(k, B_DIV, B_HD, B_HFP, B_HSW, B_HBP, B_VD, B_VFP, B_VSW, B_VBP, 1'b1, 1'b1);
    endfunction

    function automatic logic [W-1:0] obs_a();
        logic [7:0] fc;
`ifdef VGA_FRAME_CNT_EN
        fc = a_if.frame_cnt;
`else
        fc = 8'd0;
`endif
        return {a_if.hsync, a_if.vsync, a_if.video_on, a_if.p_tick, a_if.line_end,
                a_if.frame_end, a_if.pixel_x, a_if.pixel_y, fc};
    endfunction

    function automatic logic [W-1:0] obs_b();
        logic [7:0] fc;
`ifdef VGA_FRAME_CNT_EN
        fc = b_if.frame_cnt;
`else
        fc = 8'd0;
`endif
        return {b_if.hsync, b_if.vsync, b_if.video_on, b_if.p_tick, b_if.line_end,
                b_if.frame_end, b_if.pixel_x, b_if.pixel_y, fc};
    endfunction

    // Stimulus side: advance model on each edge and queue what the next sample must show.
    always @(posedge clk) begin
        if (!reset) begin
            k_a = 0;
            k_b = 0;
        end else begin
            k_a = a_if.en ? k_a + 1 : 0;
            k_b = b_if.en ? k_b + 1 : 0;
        end
        exp_a_q.push_back(exp_a(k_a));
        exp_b_q.push_back(exp_b(k_b));
    end

    // ---------------- scoreboard monitor ----------------
    task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t actual={hs,vs,von,pt,le,fe}=%b x=%0d y=%0d fc=%0d required={hs,vs,von,pt,le,fe}=%b x=%0d y=%0d fc=%0d",
                     name, $time, act[W-1:W-6], act[27:18], act[17:8], act[7:0],
                     req[W-1:W-6], req[27:18], req[17:8], req[7:0]);
        end
    endtask

    always @(negedge clk) begin
        if (exp_a_q.size() == 0 || exp_b_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL queue_empty t=%0t actual=%0d/%0d required=nonzero", $time,
                     exp_a_q.size(), exp_b_q.size());
        end else begin
            check_vec("dut_a", obs_a(), exp_a_q.pop_front());
            check_vec("dut_b", obs_b(), exp_b_q.pop_front());
        end
        if (reset && b_if.frame_end) b_frame_seen++;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_a_pixel(input int x, input int y, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (a_if.pixel_x == CW'(x) && a_if.pixel_y == CW'(y)) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s actual=timeout required=pixel(%0d,%0d)", name, x, y);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        a_if.en = 1'b1;
        b_if.en = 1'b1;
        reset   = 1'b0;
        step(3);
        @(negedge clk);
        #1 reset = 1'b1;

        // Free run across more than one full frame of instance A.
        step(1100);

        // Enable dropped mid-frame for 5 clk, then restart.
        wait_a_pixel(20, 5, "wait_en_drop");
        #1 a_if.en = 1'b0;
        step(5);
        a_if.en = 1'b1;
        step(300);

        // Random enable activity on both instances.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) a_if.en = ~a_if.en;
            if ($urandom_range(0, 99) < 3) b_if.en = ~b_if.en;
            step(1);
        end
        a_if.en = 1'b1;
        b_if.en = 1'b1;
        step(400);

        // Asynchronous reset mid-line: outputs must drop before any clk edge.
        wait_a_pixel(25, 3, "wait_reset_pt");
        #1 reset = 1'b0;
        #2;
        check_vec("async_reset_a", obs_a(), exp_a(0));
        check_vec("async_reset_b", obs_b(), exp_b(0));
        repeat (3) @(negedge clk);
        b_frame_seen = 0;
        #1 reset = 1'b1;

        // 257 frames of instance B from a clean start.
        step(257 * B_FRAME + 5);
        total++;
        if (b_frame_seen != 257) begin
            bad++;
            $display("FAIL b_frame_count actual=%0d required=257", b_frame_seen);
        end
`ifdef VGA_FRAME_CNT_EN
        @(negedge clk);
        total++;
        if (b_if.frame_cnt != 8'd1) begin
            bad++;
            $display("FAIL b_frame_cnt_wrap actual=%0d required=1", b_if.frame_cnt);
        end
`endif
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. It is the next generation of the team's fixed 640x480 sync block.
- Adds generic H/V timing, a pixel-clock divide ratio, sync polarity, an enable input, and line/frame end strobes.
- Sits between the system clock and the pixel renderers (Pong field, paddles, ball). All pixel logic qualifies on p_tick and uses pixel_x/pixel_y.

Parameters:
- CNT_W, 10, width of the H/V counters and pixel_x/pixel_y. Must hold H_TOTAL-1 and V_TOTAL-1.
- DIV, 2, clk cycles per pixel (>=1).
- HD, 640, horizontal display pixels.
- HFP, 16, horizontal front porch, after the display region.
- HSW, 96, hsync width.
- HBP, 48, horizontal back porch.
- VD, 480, vertical display lines.
- VFP, 10, vertical front porch.
- VSW, 2, vsync width.
- VBP, 33, vertical back porch.
- HS_POL, 0, active level of hsync (0 = active-low).
- VS_POL, 0, active level of vsync.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low holds the generator idle.
- hsync  out  1  registered horizontal sync.
- vsync  out  1  registered vertical sync.
- video_on  out  1  registered, high inside the active display area.
- p_tick  out  1  pixel strobe, one clk wide.
- pixel_x  out  CNT_W  current horizontal count.
- pixel_y  out  CNT_W  current vertical count.
- line_end  out  1  strobe on the last pixel of a line.
- frame_end  out  1  strobe on the last pixel of a frame.

Behaviour:
- Derived constants: H_TOTAL = HD+HFP+HSW+HBP (800); V_TOTAL = VD+VFP+VSW+VBP (525).
- Reset (asserted low, asynchronous):
  - Divider counter, h_cnt and v_cnt go to 0.
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - video_on = 0, p_tick = 0, line_end = 0, frame_end = 0.
- Divider:
  - div_cnt counts 0..DIV-1 and wraps.
  - p_tick = (div_cnt == DIV-1) & en, and is registered.
  - DIV=1 gives p_tick high every cycle while en is high, starting the first clk after reset release.
- Horizontal counter: on p_tick, h_cnt increments, wrapping H_TOTAL-1 -> 0.
- Vertical counter: on p_tick with h_cnt == H_TOTAL-1, v_cnt increments, wrapping V_TOTAL-1 -> 0.
- pixel_x = h_cnt and pixel_y = v_cnt, both taken directly from the registers.
- hsync, vsync and video_on are registered from the decode of the next-state counters, so they align exactly with pixel_x/pixel_y in every cycle (no lag, glitch-free):
  - hsync active when HD+HFP <= h <= HD+HFP+HSW-1 (656..751).
  - vsync active when VD+VFP <= v <= VD+VFP+VSW-1 (490..491).
  - video_on = en & (h < HD) & (v < VD).
- Strobes (combinational from registered state, one clk wide):
  - line_end = p_tick & (h_cnt == H_TOTAL-1).
  - frame_end = line_end & (v_cnt == V_TOTAL-1).
- en low:
  - Divider and counters clear synchronously to 0.
  - p_tick = 0, video_on = 0, syncs inactive.
  - On en rising, timing restarts from (0,0) with the first p_tick DIV cycles later.
- en dropping mid-frame: same as above; no partial line is completed.
- Reset mid-frame: immediate return to reset values, independent of clk.
- Polarity: HS_POL=1 inverts only the active level; the sync windows do not move.

Optional Feature:
- Macro VGA_FRAME_CNT_EN.
- Defined: adds output port frame_cnt, width 8.
  - Reset value 0; increments on frame_end; wraps 255 -> 0.
  - Cleared with the counters when en is low.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package vga_pkg holds:
  - Default 640x480@60 timing constants (HD, HFP, HSW, HBP, VD, VFP, VSW, VBP).
  - Derived H_TOTAL/V_TOTAL functions.
  - A clog2-based counter-width helper.
- One sub-module: vga_tick_div, the generic DIV-ratio strobe generator with enable. It is reusable by other blocks.

Test Plan:
- Defaults, en=1, run one full frame:
  - p_tick every 2nd clk.
  - frame_end exactly once per 800*525*2 = 840000 clk.
  - pixel_x wraps 799 -> 0; pixel_y wraps 524 -> 0.
- hsync low exactly for pixel_x 656..751 (96 ticks); vsync low exactly for pixel_y 490..491; video_on high iff x<640 and y<480; all checked in the same cycle as pixel_x/pixel_y.
- DIV=1, HS_POL=1, VS_POL=1: p_tick continuously high; hsync high for 656..751; line period 800 clk.
- en dropped at (x=300, y=200) for 5 clk, then raised: immediate video_on=0 and counters 0; restart at (0,0); first p_tick 2 clk after en rises.
- reset asserted asynchronously mid-line at x=700: all outputs take reset values before the next clk edge; after release, timing starts from (0,0).
- VGA_FRAME_CNT_EN defined, 257 frames: frame_cnt reads 1 after the first frame_end and wraps to 1 after the 257th.
